// File: rtl/filter_ctrl_pkg.sv
// Shared FSM encoding, vertical pad one-hot codes and frame size limits for the
// 5x5 filter line-memory controller.
package filter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2,
    ST_FLUSH  = 2'd3
  } ctrl_state_e;

  // Bit order: [0] first row, [1] second row, [2] last row, [3] second-last row
  localparam logic [3:0] PAD_TOP0 = 4'b0001;
  localparam logic [3:0] PAD_TOP1 = 4'b0010;
  localparam logic [3:0] PAD_BOT0 = 4'b0100;
  localparam logic [3:0] PAD_BOT1 = 4'b1000;

  localparam int MIN_H_SIZE = 3;
  localparam int MIN_V_SIZE = 4;

endpackage

// File: rtl/filter_hv_counter.sv
// Column/line counter advanced by the read strobe, with end-of-line, last-input-line
// and last-flush-line flags compared against the latched frame geometry.
module filter_hv_counter
  import filter_ctrl_pkg::*;
#(
  parameter int COL_WIDTH  = 11,
  parameter int LINE_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  step_i,
  input  logic [COL_WIDTH-1:0]  hSize_i,
  input  logic [LINE_WIDTH-1:0] vSize_i,
  output logic [COL_WIDTH-1:0]  col_o,
  output logic [LINE_WIDTH-1:0] line_o,
  output logic                  lastPix_o,
  output logic                  lastLine_o,
  output logic                  lastFlush_o
);

  logic [COL_WIDTH-1:0]  col_q, col_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;

  assign col_o       = col_q;
  assign line_o      = line_q;
  assign lastPix_o   = (col_q == hSize_i - COL_WIDTH'(1));
  assign lastLine_o  = (line_q == vSize_i - LINE_WIDTH'(1));
  assign lastFlush_o = (line_q == vSize_i + LINE_WIDTH'(1));

  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    if (clear_i) begin
      col_d  = '0;
      line_d = '0;
    end else if (step_i) begin
      if (lastPix_o) begin
        col_d  = '0;
        line_d = line_q + LINE_WIDTH'(1);
      end else begin
        col_d = col_q + COL_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      line_q <= '0;
    end else begin
      col_q  <= col_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/filter_mem_ctrl_5x5.sv
// Line-memory controller for the 5x5 Y data-align stage: memory strobes and addresses,
// line-rotation and vertical-pad selects, and two flush lines after each frame.
module filter_mem_ctrl_5x5
  import filter_ctrl_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 11,
  parameter int MEM_Y_WIDTH    = 4,
  parameter int MEM_U_WIDTH    = 2,
  parameter int MEM_V_WIDTH    = 2,
  parameter int V_WIDTH        = 11,
  parameter int FLUSH_GAP      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_frame_start,
  input  logic [MEM_ADDR_WIDTH-1:0] i_h_size,
  input  logic [V_WIDTH-1:0]        i_v_size,
  input  logic                      i_input_de,
  output logic                      o_mem_de,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_waddr,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_raddr,
  output logic [MEM_Y_WIDTH-1:0]    o_mem_y_wen,
  output logic                      o_mem_y_ren,
  output logic [MEM_U_WIDTH-1:0]    o_mem_u_wen,
  output logic [MEM_V_WIDTH-1:0]    o_mem_v_wen,
  output logic [MEM_U_WIDTH-1:0]    o_mem_u_ren,
  output logic [MEM_V_WIDTH-1:0]    o_mem_v_ren,
  output logic [MEM_Y_WIDTH-1:0]    o_aln_ln_y,
  output logic [3:0]                o_pad_ln_y,
  output logic                      o_busy,
  output logic                      o_frame_done
);

  // Line indices need room for v_size plus the two flush lines
  localparam int LW = V_WIDTH + 1;
  localparam int GW = $clog2(FLUSH_GAP + 1);

  ctrl_state_e               state_q;
  logic                      busy_q;
  logic [MEM_ADDR_WIDTH-1:0] hSize_q, hSize_d;
  logic [LW-1:0]             vSize_q, vSize_d;
  logic [GW-1:0]             gapCnt_q;

  logic                      frameStart, rs, wenOn;
  logic [MEM_ADDR_WIDTH-1:0] col;
  logic [LW-1:0]             lineIdx;
  logic                      lastPix, lastLine, lastFlush;

  logic                      memDe_q, wLast_q, frameDone_q;
  logic [MEM_ADDR_WIDTH-1:0] waddr_q;
  logic [MEM_Y_WIDTH-1:0]    yWen_q;
  logic [MEM_U_WIDTH-1:0]    uWen_q;
  logic [MEM_V_WIDTH-1:0]    vWen_q;
  logic [LW-1:0]             wn_q;
  logic [3:0]                padSel;

  assign frameStart = (state_q == ST_IDLE) && i_frame_start;
  assign rs         = ((state_q == ST_ACTIVE) && i_input_de) || (state_q == ST_FLUSH);
  assign wenOn      = rs && (state_q != ST_FLUSH);
  assign hSize_d    = (i_h_size < MEM_ADDR_WIDTH'(MIN_H_SIZE)) ? MEM_ADDR_WIDTH'(MIN_H_SIZE) : i_h_size;
  assign vSize_d    = (i_v_size < V_WIDTH'(MIN_V_SIZE)) ? LW'(MIN_V_SIZE) : {1'b0, i_v_size};

  filter_hv_counter #(
    .COL_WIDTH  (MEM_ADDR_WIDTH),
    .LINE_WIDTH (LW)
  ) u_hv_counter (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (frameStart),
    .step_i      (rs),
    .hSize_i     (hSize_q),
    .vSize_i     (vSize_q),
    .col_o       (col),
    .line_o      (lineIdx),
    .lastPix_o   (lastPix),
    .lastLine_o  (lastLine),
    .lastFlush_o (lastFlush)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      hSize_q  <= MEM_ADDR_WIDTH'(MIN_H_SIZE);
      vSize_q  <= LW'(MIN_V_SIZE);
      gapCnt_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_frame_start) begin
            hSize_q <= hSize_d;
            vSize_q <= vSize_d;
            state_q <= ST_ACTIVE;
            busy_q  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (rs && lastPix && lastLine) begin
            state_q  <= ST_GAP;
            gapCnt_q <= '0;
          end
        end
        ST_GAP: begin
          if (gapCnt_q == GW'(FLUSH_GAP - 1)) begin
            state_q <= ST_FLUSH;
          end else begin
            gapCnt_q <= gapCnt_q + GW'(1);
          end
        end
        ST_FLUSH: begin
          if (lastPix) begin
            gapCnt_q <= '0;
            if (lastFlush) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_GAP;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Write side trails the read side by one cycle so each location is read before overwrite
  always_ff @(posedge clk) begin
    if (rst) begin
      memDe_q     <= 1'b0;
      waddr_q     <= '0;
      yWen_q      <= '0;
      uWen_q      <= '0;
      vWen_q      <= '0;
      wLast_q     <= 1'b0;
      wn_q        <= '0;
      frameDone_q <= 1'b0;
    end else begin
      memDe_q     <= rs && (lineIdx >= LW'(2));
      waddr_q     <= col;
      yWen_q      <= wenOn ? (MEM_Y_WIDTH'(1) << lineIdx[1:0]) : '0;
      uWen_q      <= wenOn ? (MEM_U_WIDTH'(1) << lineIdx[0]) : '0;
      vWen_q      <= wenOn ? (MEM_V_WIDTH'(1) << lineIdx[0]) : '0;
      wLast_q     <= rs && lastPix;
      frameDone_q <= wLast_q && (wn_q == vSize_q + LW'(1));
      if (frameStart) begin
        wn_q <= '0;
      end else if (wLast_q) begin
        wn_q <= wn_q + LW'(1);
      end
    end
  end

  always_comb begin
    padSel = '0;
    if (wn_q == LW'(2)) begin
      padSel = PAD_TOP0;
    end else if (wn_q == LW'(3)) begin
      padSel = PAD_TOP1;
    end else if (wn_q == vSize_q) begin
      padSel = PAD_BOT1;
    end else if (wn_q == vSize_q + LW'(1)) begin
      padSel = PAD_BOT0;
    end
  end

  assign o_mem_y_ren  = rs;
  assign o_mem_u_ren  = rs ? (MEM_U_WIDTH'(1) << lineIdx[0]) : '0;
  assign o_mem_v_ren  = rs ? (MEM_V_WIDTH'(1) << lineIdx[0]) : '0;
  assign o_mem_raddr  = col;
  assign o_mem_de     = memDe_q;
  assign o_mem_waddr  = waddr_q;
  assign o_mem_y_wen  = yWen_q;
  assign o_mem_u_wen  = uWen_q;
  assign o_mem_v_wen  = vWen_q;
  assign o_aln_ln_y   = MEM_Y_WIDTH'(1) << wn_q[1:0];
  assign o_pad_ln_y   = padSel;
  assign o_busy       = busy_q;
  assign o_frame_done = frameDone_q;

endmodule

// File: tb/tb_filter_mem_ctrl_5x5.sv
// Bench for filter_mem_ctrl_5x5: per-frame strobe timeline built from the frame rules,
// every output predicted from strobe counts and compared each cycle.
module tb_filter_mem_ctrl_5x5;

  localparam int FLUSH_GAP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frameStart = 1'b0;
  logic [10:0] hSize = '0;
  logic [10:0] vSize = '0;
  logic        inputDe = 1'b0;

  logic        memDe, yRen, busy, frameDone;
  logic [10:0] waddr, raddr;
  logic [3:0]  yWen, aln, pad;
  logic [1:0]  uWen, vWen, uRen, vRen;

  int vectors = 0;
  int miscompares = 0;
  int curFrame = 0;
  int curCycle = 0;
  int lastWn = 0;

  always #5 clk = ~clk;

  filter_mem_ctrl_5x5 #(
    .MEM_ADDR_WIDTH (11),
    .MEM_Y_WIDTH    (4),
    .MEM_U_WIDTH    (2),
    .MEM_V_WIDTH    (2),
    .V_WIDTH        (11),
    .FLUSH_GAP      (FLUSH_GAP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_frame_start (frameStart),
    .i_h_size      (hSize),
    .i_v_size      (vSize),
    .i_input_de    (inputDe),
    .o_mem_de      (memDe),
    .o_mem_waddr   (waddr),
    .o_mem_raddr   (raddr),
    .o_mem_y_wen   (yWen),
    .o_mem_y_ren   (yRen),
    .o_mem_u_wen   (uWen),
    .o_mem_v_wen   (vWen),
    .o_mem_u_ren   (uRen),
    .o_mem_v_ren   (vRen),
    .o_aln_ln_y    (aln),
    .o_pad_ln_y    (pad),
    .o_busy        (busy),
    .o_frame_done  (frameDone)
  );

  // Drive one cycle's inputs on the falling edge, then settle before sampling
  task automatic applyStimulus(input logic r, input logic s, input logic de, input int h, input int v);
    @(negedge clk);
    rst        = r;
    frameStart = s;
    inputDe    = de;
    hSize      = 11'(h);
    vSize      = 11'(v);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s (frame %0d cycle %0d): observed 'h%0h, expected 'h%0h",
             tag, curFrame, curCycle, observed, expected);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_mem_de", 32'(memDe), 0);
    checkOutput("rst_waddr", 32'(waddr), 0);
    checkOutput("rst_raddr", 32'(raddr), 0);
    checkOutput("rst_y_wen", 32'(yWen), 0);
    checkOutput("rst_y_ren", 32'(yRen), 0);
    checkOutput("rst_u_wen", 32'(uWen), 0);
    checkOutput("rst_v_wen", 32'(vWen), 0);
    checkOutput("rst_u_ren", 32'(uRen), 0);
    checkOutput("rst_v_ren", 32'(vRen), 0);
    checkOutput("rst_aln", 32'(aln), 1);
    checkOutput("rst_pad", 32'(pad), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(frameDone), 0);
  endtask

  task automatic doReset(input int cycles);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < cycles; i++) begin
      curCycle = i;
      applyStimulus(1'b1, 1'b0, 1'b1, 8, 6);
      checkReset();
    end
    lastWn = 0;
  endtask

  // mode: 0 = lines with 4-cycle blanking, 1 = DE 1-on/1-off, 2 = zero blanking, 3 = random DE.
  // abortAt >= 0 stops driving the frame at that cycle (caller then resets).
  task automatic runFrame(input int hReq, input int vReq, input int mode, input int abortAt);
    int  h, v, cnt, lastStrobe;
    int  s, sPrev, nCur, nPrev, wn, expPad, expYWen, expCWen;
    bit  deNow, rsCur, rsPrev, startNow;
    bit  rsQ[$];
    bit  deQ[$];
    h = (hReq < 3) ? 3 : hReq;
    v = (vReq < 4) ? 4 : vReq;
    curFrame++;
    deQ.push_back(1'b0);
    rsQ.push_back(1'b0);
    cnt = 0;
    while (cnt < h * v) begin
      case (mode)
        0:       deNow = ((rsQ.size() - 1) % (h + 4)) < h;
        1:       deNow = ((rsQ.size() - 1) % 2) == 0;
        2:       deNow = 1'b1;
        default: deNow = ($urandom_range(0, 99) < 70);
      endcase
      deQ.push_back(deNow);
      rsQ.push_back(deNow);
      if (deNow) cnt++;
    end
    // Two flush lines, each preceded by FLUSH_GAP idle cycles; DE there is noise
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FLUSH_GAP; i++) begin
        deQ.push_back(1'($urandom_range(0, 1)));
        rsQ.push_back(1'b0);
      end
      for (int i = 0; i < h; i++) begin
        deQ.push_back(1'($urandom_range(0, 1)));
        rsQ.push_back(1'b1);
      end
    end
    lastStrobe = rsQ.size() - 1;
    for (int i = 0; i < 6; i++) begin
      deQ.push_back(1'($urandom_range(0, 1)));
      rsQ.push_back(1'b0);
    end

    s = 0;
    sPrev = 0;
    rsPrev = 1'b0;
    for (int t = 0; t < rsQ.size(); t++) begin
      if (t == abortAt) break;
      curCycle = t;
      startNow = (t == 0) || (t == lastStrobe) ||
                 (t >= 1 && t <= lastStrobe && $urandom_range(0, 24) == 0);
      applyStimulus(1'b0, startNow, deQ[t],
                    (t == 0) ? hReq : int'($urandom_range(0, 2047)),
                    (t == 0) ? vReq : int'($urandom_range(0, 2047)));
      rsCur  = rsQ[t];
      nCur   = s / h;
      nPrev  = sPrev / h;
      wn     = (t == 0) ? lastWn : nPrev;
      expPad = (wn == 2) ? 1 : (wn == 3) ? 2 : (wn == v) ? 8 : (wn == v + 1) ? 4 : 0;
      if (t == 0) expPad = 0;
      expYWen = (rsPrev && nPrev < v) ? (1 << (nPrev % 4)) : 0;
      expCWen = (rsPrev && nPrev < v) ? (1 << (nPrev % 2)) : 0;

      checkOutput("raddr", 32'(raddr), s % h);
      checkOutput("y_ren", 32'(yRen), int'(rsCur));
      checkOutput("u_ren", 32'(uRen), rsCur ? (1 << (nCur % 2)) : 0);
      checkOutput("v_ren", 32'(vRen), rsCur ? (1 << (nCur % 2)) : 0);
      checkOutput("waddr", 32'(waddr), sPrev % h);
      checkOutput("y_wen", 32'(yWen), expYWen);
      checkOutput("u_wen", 32'(uWen), expCWen);
      checkOutput("v_wen", 32'(vWen), expCWen);
      checkOutput("mem_de", 32'(memDe), (rsPrev && nPrev >= 2) ? 1 : 0);
      checkOutput("aln", 32'(aln), 1 << (wn % 4));
      checkOutput("pad", 32'(pad), expPad);
      checkOutput("busy", 32'(busy), (t >= 1 && t <= lastStrobe) ? 1 : 0);
      checkOutput("frame_done", 32'(frameDone), (t == lastStrobe + 2) ? 1 : 0);

      sPrev = s;
      if (rsCur) s++;
      rsPrev = rsCur;
    end
    if (abortAt < 0) lastWn = v + 2;
  endtask

  initial begin
    $display("[TB] reset");
    doReset(3);
    $display("[TB] contiguous frame h=8 v=6, 4-cycle blanking");
    runFrame(8, 6, 0, -1);
    $display("[TB] gapped DE frame h=8 v=5");
    runFrame(8, 5, 1, -1);
    $display("[TB] zero-blanking frame h=8 v=4");
    runFrame(8, 4, 2, -1);
    $display("[TB] frame aborted by reset in line 3");
    runFrame(8, 6, 0, 40);
    doReset(2);
    runFrame(8, 6, 0, -1);
    $display("[TB] random frames, including undersized geometry");
    runFrame(1, 2, 3, -1);
    for (int i = 0; i < 4; i++) begin
      runFrame(int'($urandom_range(1, 12)), int'($urandom_range(2, 7)), 3, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
